// File: rtl/arith_seq_unit.sv
// Sequential arithmetic unit: single-cycle ADD/SUB/RSUB and a WIDTH-cycle
// unsigned shift-add multiplier, with registered result, status flags and handshake.
module arith_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic [WIDTH-1:0] ResultC,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Overflow,
    output logic             CarryOut,
    output logic             Negative,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);

    localparam int            CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [1:0]    OP_SUB    = 2'b01;
    localparam logic [1:0]    OP_MUL    = 2'b10;
    localparam logic [1:0]    OP_RSUB   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        MUL  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CW-1:0]    step;

    logic [WIDTH-1:0] lhs;
    logic [WIDTH-1:0] rhs;
    logic [WIDTH-1:0] rhs_eff;
    logic             is_sub;
    logic [WIDTH:0]   sum;
    logic             alu_ovf;
    logic [WIDTH:0]   part;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    logic             load_res;
    logic [WIDTH-1:0] c_d;
    logic [WIDTH-1:0] hi_d;
    logic             ovf_d;
    logic             cy_d;
    logic             neg_d;
    logic             zero_d;
    logic             busy_d;
    logic             done_d;

    // RSUB reuses the subtract path with the operands swapped
    always_comb begin
        lhs    = a_q;
        rhs    = b_q;
        is_sub = 1'b0;
        case (op_q)
            OP_SUB:  is_sub = 1'b1;
            OP_RSUB: begin
                lhs    = b_q;
                rhs    = a_q;
                is_sub = 1'b1;
            end
            default: is_sub = 1'b0;
        endcase
        rhs_eff = is_sub ? ~rhs : rhs;
        sum     = {1'b0, lhs} + {1'b0, rhs_eff} + {{WIDTH{1'b0}}, is_sub};
        if (is_sub) begin
            alu_ovf = (lhs[WIDTH-1] != rhs[WIDTH-1]) && (sum[WIDTH-1] != lhs[WIDTH-1]);
        end else begin
            alu_ovf = (lhs[WIDTH-1] == rhs[WIDTH-1]) && (sum[WIDTH-1] != lhs[WIDTH-1]);
        end
    end

    // One shift-add step: the low half starts as the multiplier and is shifted out
    always_comb begin
        part   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : {(WIDTH + 1){1'b0}});
        nxt_hi = part[WIDTH:1];
        nxt_lo = {part[0], acc_lo[WIDTH-1:1]};
    end

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    next_state = (Op == OP_MUL) ? MUL : CALC;
                end else begin
                    next_state = IDLE;
                end
            end
            CALC: next_state = DONE;
            MUL: begin
                if (step == LAST_STEP) begin
                    next_state = DONE;
                end else begin
                    next_state = MUL;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: values loaded into the result registers on entry to DONE
    always_comb begin
        load_res = (next_state == DONE);
        busy_d   = (next_state != IDLE);
        done_d   = (next_state == DONE);
        if (state == MUL) begin
            c_d    = nxt_lo;
            hi_d   = nxt_hi;
            ovf_d  = |nxt_hi;
            cy_d   = 1'b0;
            neg_d  = nxt_lo[WIDTH-1];
            zero_d = ~|{nxt_hi, nxt_lo};
        end else begin
            c_d    = sum[WIDTH-1:0];
            hi_d   = {WIDTH{1'b0}};
            ovf_d  = alu_ovf;
            cy_d   = sum[WIDTH];
            neg_d  = sum[WIDTH-1];
            zero_d = ~|sum[WIDTH-1:0];
        end
    end

    // Operand capture, multiplier accumulator and registered outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            op_q     <= 2'b00;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            acc_hi   <= {WIDTH{1'b0}};
            acc_lo   <= {WIDTH{1'b0}};
            step     <= {CW{1'b0}};
            ResultC  <= {WIDTH{1'b0}};
            ResultHi <= {WIDTH{1'b0}};
            Overflow <= 1'b0;
            CarryOut <= 1'b0;
            Negative <= 1'b0;
            Zero     <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            if (state == IDLE && Start) begin
                op_q   <= Op;
                a_q    <= DataA;
                b_q    <= DataB;
                acc_hi <= {WIDTH{1'b0}};
                acc_lo <= DataB;
                step   <= {CW{1'b0}};
            end else if (state == MUL) begin
                acc_hi <= nxt_hi;
                acc_lo <= nxt_lo;
                step   <= step + {{(CW - 1){1'b0}}, 1'b1};
            end
            if (load_res) begin
                ResultC  <= c_d;
                ResultHi <= hi_d;
                Overflow <= ovf_d;
                CarryOut <= cy_d;
                Negative <= neg_d;
                Zero     <= zero_d;
            end
            Busy <= busy_d;
            Done <= done_d;
        end
    end

endmodule

// File: tb/tb_arith_seq_unit.sv
// Self-checking bench for arith_seq_unit: a cycle-level behavioural model is
// compared every cycle, plus directed cases with hand-computed literal results.
module tb_arith_seq_unit;

    localparam int     W    = 32;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] DataA;
    logic [W-1:0] DataB;
    logic [W-1:0] ResultC;
    logic [W-1:0] ResultHi;
    logic         Overflow;
    logic         CarryOut;
    logic         Negative;
    logic         Zero;
    logic         Busy;
    logic         Done;

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    always #5 Clock = ~Clock;

    arith_seq_unit #(.WIDTH(W)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Op       (Op),
        .DataA    (DataA),
        .DataB    (DataB),
        .ResultC  (ResultC),
        .ResultHi (ResultHi),
        .Overflow (Overflow),
        .CarryOut (CarryOut),
        .Negative (Negative),
        .Zero     (Zero),
        .Busy     (Busy),
        .Done     (Done)
    );

    // Reference result as {C, Hi, Overflow, CarryOut, Negative, Zero}
    function automatic logic [67:0] model_op(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [63:0]  p;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic [W-1:0] hi;
        longint       sres;
        logic         cy;
        logic         ovf;
        if (op == 2'b10) begin
            p  = 64'(a) * 64'(b);
            r  = p[31:0];
            hi = p[63:32];
            return {r, hi, (hi != 32'd0), 1'b0, r[W-1], (p == 64'd0)};
        end
        x = (op == 2'b11) ? b : a;
        y = (op == 2'b11) ? a : b;
        if (op == 2'b00) begin
            p    = 64'(x) + 64'(y);
            cy   = p[32];
            sres = longint'($signed(x)) + longint'($signed(y));
        end else begin
            p    = 64'(x) - 64'(y);
            cy   = (x >= y);
            sres = longint'($signed(x)) - longint'($signed(y));
        end
        r   = p[31:0];
        ovf = (sres > SMAX) || (sres < SMIN);
        return {r, 32'd0, ovf, cy, r[W-1], (r == 32'd0)};
    endfunction

    // Model: idle / counting down to completion / one-cycle done
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_left = 0;
    logic [67:0] m_out  = '0;
    logic [67:0] m_pend = '0;

    always @(posedge Clock) begin
        if (Reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_out  <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_out  <= m_pend;
            end
        end else if (Start) begin
            m_busy <= 1'b1;
            m_left <= (Op == 2'b10) ? W : 1;
            m_pend <= model_op(Op, DataA, DataB);
        end
    end

    always @(negedge Clock) begin
        if (chk_en) begin
            checks++;
            if ({Busy, Done} !== {m_busy, m_done}) begin
                failures++;
                $display("FAIL ctrl @%0t: Busy,Done got %b%b expected %b%b", $time, Busy, Done,
                         m_busy, m_done);
            end
            checks++;
            if ({ResultC, ResultHi, Overflow, CarryOut, Negative, Zero} !== m_out) begin
                failures++;
                $display("FAIL outputs @%0t: got %h expected %h", $time,
                         {ResultC, ResultHi, Overflow, CarryOut, Negative, Zero}, m_out);
            end
        end
    end

    task automatic expect_val(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Issue one op, measure latency in cycles after the Start cycle, check literals
    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_c,
                          input logic [W-1:0] exp_hi, input logic [3:0] exp_flags,
                          input int exp_lat);
        int lat      = 0;
        int busy_cnt = 0;
        @(negedge Clock);
        #1;
        Start = 1'b1;
        Op    = op;
        DataA = a;
        DataB = b;
        for (int n = 1; n <= W + 8; n++) begin
            @(negedge Clock);
            if (Busy) busy_cnt++;
            if (Done) begin
                lat = n;
                break;
            end
            #1;
            Start = 1'b0;
            DataA = $urandom;
            DataB = $urandom;
        end
        #1;
        Start = 1'b0;
        expect_val({name, " latency"}, 128'(lat), 128'(exp_lat));
        expect_val({name, " busy_cycles"}, 128'(busy_cnt), 128'(exp_lat));
        expect_val({name, " ResultC"}, 128'(ResultC), 128'(exp_c));
        expect_val({name, " ResultHi"}, 128'(ResultHi), 128'(exp_hi));
        expect_val({name, " ovf_cy_neg_z"}, 128'({Overflow, CarryOut, Negative, Zero}),
                   128'(exp_flags));
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corners [5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int done_seen;
        Reset = 1'b1;
        Start = 1'b0;
        Op    = 2'b00;
        DataA = '0;
        DataB = '0;
        repeat (2) @(negedge Clock);
        expect_val("reset outputs", 128'({ResultC, ResultHi, Overflow, CarryOut, Negative, Zero,
                   Busy, Done}), 128'd0);
        #1;
        Reset  = 1'b0;
        chk_en = 1'b1;

        run_op("add_ovf", 2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'd0, 4'b1010, 2);
        run_op("add_carry", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'd0, 4'b0101, 2);
        run_op("sub_5_7", 2'b01, 32'd5, 32'd7, 32'hFFFF_FFFE, 32'd0, 4'b0010, 2);
        run_op("sub_min_1", 2'b01, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 32'd0, 4'b1100, 2);
        run_op("rsub_7_5", 2'b11, 32'd7, 32'd5, 32'hFFFF_FFFE, 32'd0, 4'b0010, 2);
        run_op("mul_zero", 2'b10, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'b0001, 33);
        run_op("mul_max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE,
               4'b1000, 33);

        // MUL aborted by Reset, with an ignored Start mid-operation
        @(negedge Clock);
        #1;
        Start = 1'b1;
        Op    = 2'b10;
        DataA = 32'd3;
        DataB = 32'd4;
        done_seen = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge Clock);
            if (Done) done_seen++;
            if (c == 11) begin
                expect_val("abort outputs", 128'({ResultC, ResultHi, Overflow, CarryOut, Negative,
                           Zero, Busy, Done}), 128'd0);
            end
            #1;
            Start = (c == 5);
            Reset = (c == 10);
            Op    = (c == 5) ? 2'b00 : 2'b10;
            DataA = (c == 3 || c == 5) ? 32'd99 : DataA;
        end
        expect_val("abort no_done", 128'(done_seen), 128'd0);
        run_op("add_after_abort", 2'b00, 32'd1, 32'd1, 32'd2, 32'd0, 4'b0000, 2);

        // Start coincident with Reset is discarded
        @(negedge Clock);
        #1;
        Start = 1'b1;
        Reset = 1'b1;
        @(negedge Clock);
        expect_val("start_with_reset busy", 128'(Busy), 128'd0);
        #1;
        Start = 1'b0;
        Reset = 1'b0;
        @(negedge Clock);
        expect_val("start_with_reset idle", 128'(Busy), 128'd0);

        for (int i = 0; i < 4000; i++) begin
            @(negedge Clock);
            #1;
            Start = ($urandom_range(0, 2) == 0);
            Op    = 2'($urandom_range(0, 3));
            DataA = pick_operand();
            DataB = pick_operand();
            Reset = ($urandom_range(0, 150) == 0);
        end
        @(negedge Clock);
        #1;
        Start = 1'b0;
        Reset = 1'b0;
        repeat (2) @(negedge Clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arith_seq_unit.md
ARITH_SEQ_UNIT -- requirements
Module: arith_seq_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand/result width in bits; legal range 4..64.
REQ-002 SHALL have port Clock, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port Start, input, 1, operation request; sampled only in IDLE.
REQ-005 SHALL have port Op, input, 2, operation: 00 ADD, 01 SUB (A-B), 10 MUL (unsigned), 11 RSUB (B-A).
REQ-006 SHALL have ports DataA and DataB, input, WIDTH each, the operands.
REQ-007 SHALL have port ResultC, output, WIDTH, the result, or the low product half for MUL.
REQ-008 SHALL have port ResultHi, output, WIDTH, the high product half for MUL; 0 for other ops.
REQ-009 SHALL have ports Overflow, CarryOut, Negative and Zero, output, 1 each, the status flags.
REQ-010 SHALL have port Busy, output, 1, high while an operation is in progress.
REQ-011 SHALL have port Done, output, 1, a one-cycle pulse marking result/flags valid.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC, MUL and DONE.
REQ-013 IDLE with Start=1: SHALL latch DataA, DataB and Op internally; go to MUL if Op=10, else CALC.
REQ-014 IDLE with Start=0: SHALL remain in IDLE.
REQ-015 CALC: SHALL compute the result in one cycle, register ResultC and the flags, then go to DONE.
REQ-016 MUL: SHALL perform an unsigned shift-add using a step counter over exactly WIDTH cycles, register the 2*WIDTH product, then go to DONE.
REQ-017 DONE: SHALL assert Done for exactly one cycle, then go to IDLE.
REQ-018 Latency: with Start accepted in cycle 0, Done SHALL be high in cycle 2 for ADD/SUB/RSUB and in cycle WIDTH+1 for MUL.
REQ-019 Busy SHALL be high in CALC, MUL and DONE, and low in IDLE.
REQ-020 Start while not in IDLE SHALL be ignored: no effect on the latched operands, Op or timing.
REQ-021 Operands SHALL be taken from the latched copies; DataA/DataB changes after acceptance SHALL have no effect.
REQ-022 ResultC, ResultHi and the flags SHALL change only on the DONE transition and hold until the next completion or Reset.
REQ-023 ADD: SHALL produce R = A+B mod 2^WIDTH.
REQ-024 ADD flags: CarryOut = carry out of the MSB; Overflow = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
REQ-025 SUB: SHALL compute R = A + ~B + 1.
REQ-026 SUB flags: CarryOut = carry out of the MSB (1 = no borrow); Overflow = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
REQ-027 RSUB: SHALL follow the SUB rules with the operands swapped.
REQ-028 ADD/SUB/RSUB: Negative = R[msb]; Zero = (R==0); ResultHi = 0.
REQ-029 MUL: {ResultHi,ResultC} SHALL equal A*B exactly, with no truncation.
REQ-030 MUL flags: CarryOut = 0; Overflow = (ResultHi!=0); Negative = ResultC[msb]; Zero = (full product==0).
REQ-031 A Start accepted in the same cycle as Reset SHALL be discarded.

Reset
REQ-032 Reset=1 at a rising edge SHALL set the state to IDLE and clear the step counter.
REQ-033 Reset SHALL drive ResultC, ResultHi, Overflow, CarryOut, Negative, Zero, Busy and Done to 0, and clear the latched operands.
REQ-034 Reset in CALC, MUL or DONE SHALL abort the operation; no Done pulse SHALL follow.
REQ-035 Reset SHALL take priority over Start and all state transitions.

Verification (WIDTH=32)
REQ-036 Bench SHALL cover ADD 0x7FFFFFFF+0x00000001, Start in cycle 0 -> Done in cycle 2, ResultC=0x80000000, Overflow=1, Negative=1, CarryOut=0, Zero=0.
REQ-037 Bench SHALL cover ADD 0xFFFFFFFF+0x00000001 -> ResultC=0, CarryOut=1, Zero=1, Overflow=0, ResultHi=0.
REQ-038 Bench SHALL cover SUB 5-7 -> ResultC=0xFFFFFFFE, CarryOut=0, Negative=1; SUB 0x80000000-1 -> ResultC=0x7FFFFFFF, Overflow=1, CarryOut=1.
REQ-039 Bench SHALL cover RSUB A=7, B=5 -> ResultC=0xFFFFFFFE, identical to SUB 5-7.
REQ-040 Bench SHALL cover MUL 0xFFFFFFFF*0xFFFFFFFF -> Done in cycle 33, ResultHi=0xFFFFFFFE, ResultC=0x00000001, Overflow=1, Negative=0, Zero=0; Busy high in cycles 1..33.
REQ-041 Bench SHALL cover MUL 3*4 with Start re-pulsed in cycle 5 and Reset in cycle 10 -> second Start ignored; Busy=0 and all outputs 0 from cycle 11; no Done; a new ADD 1+1 then completes normally with ResultC=2.
